// File: rtl/bp_common_pkg.sv
// Shared types for the commit trace checker: expected-record layout, checker
// state encoding and the record compare helper.
package bp_common_pkg;

   localparam int unsigned bp_vaddr_width_gp = 39;
   localparam int unsigned bp_instr_width_gp = 32;
   localparam int unsigned bp_dword_width_gp = 64;

   typedef enum logic [1:0] {
      e_check_idle = 2'd0,
      e_check_run  = 2'd1,
      e_check_pass = 2'd2,
      e_check_fail = 2'd3
   } bp_commit_check_state_e;

   typedef struct packed {
      logic [bp_vaddr_width_gp-1:0] pc;
      logic [bp_instr_width_gp-1:0] instr;
      logic                         rd_w_v;
      logic [4:0]                   rd_addr;
      logic [bp_dword_width_gp-1:0] rd_data;
      logic                         last;
   } bp_commit_trace_rec_s;

   // bit0 PC, bit1 instr, bit2 writeback; rd address/data only matter when a write is expected
   function automatic logic [2:0] bp_compare_rec(
      input bp_commit_trace_rec_s         rec,
      input logic [bp_vaddr_width_gp-1:0] pc,
      input logic [bp_instr_width_gp-1:0] instr,
      input logic                         rd_w_v,
      input logic [4:0]                   rd_addr,
      input logic [bp_dword_width_gp-1:0] rd_data
   );
      logic [2:0] code;
      code[0] = (rec.pc != pc);
      code[1] = (rec.instr != instr);
      code[2] = (rec.rd_w_v != rd_w_v)
              || (rec.rd_w_v && ((rec.rd_addr != rd_addr) || (rec.rd_data != rd_data)));
      return code;
   endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO with valid/ready on the write side and
// valid/yumi on the read side; the occupancy counter spans 0..els_p inclusive.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 8,
   parameter int els_p   = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [width_p-1:0]  mem_r [els_p];
   logic [ptr_w_lp-1:0] wptr_r, rptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic                enq, deq;

   // Write side: data_i is taken on a cycle where v_i & ready_o; read side pops on yumi_i & v_o.
   assign ready_o = (count_r != cnt_w_lp'(els_p));
   assign v_o     = (count_r != '0);
   assign data_o  = mem_r[rptr_r];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (enq)
            wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
         if (deq)
            rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
         case ({enq, deq})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq)
         mem_r[wptr_r] <= data_i;
   end

endmodule

// File: rtl/bp_commit_trace_checker.sv
// Compares the core's commit stream (PC, instruction, delayed writeback)
// against a buffered expected trace and reports pass/fail with a cause code.
module bp_commit_trace_checker
   import bp_common_pkg::*;
#(
   parameter int vaddr_width_p  = 39,
   parameter int instr_width_p  = 32,
   parameter int dword_width_p  = 64,
   parameter int exp_fifo_els_p = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     en_i,
   input  logic                     exp_v_i,
   output logic                     exp_ready_o,
   input  logic [vaddr_width_p-1:0] exp_pc_i,
   input  logic [instr_width_p-1:0] exp_instr_i,
   input  logic                     exp_rd_w_v_i,
   input  logic [4:0]               exp_rd_addr_i,
   input  logic [dword_width_p-1:0] exp_rd_data_i,
   input  logic                     exp_last_i,
   input  logic                     commit_v_i,
   input  logic [vaddr_width_p-1:0] commit_pc_i,
   input  logic [instr_width_p-1:0] commit_instr_i,
   input  logic                     rd_w_v_i,
   input  logic [4:0]               rd_addr_i,
   input  logic [dword_width_p-1:0] rd_data_i,
   output logic [1:0]               state_o,
   output logic [31:0]              match_cnt_o,
   output logic [31:0]              fail_itag_o,
   output logic [2:0]               fail_code_o,
   output logic                     pass_o,
   output logic                     fail_o
);

   bp_commit_check_state_e state_r, state_n;
   bp_commit_trace_rec_s   push_rec, head_rec;

   logic                     fifo_ready, fifo_v, fifo_push, fifo_yumi;
   logic                     c1_v_r, c2_v_r;
   logic [vaddr_width_p-1:0] c1_pc_r, c2_pc_r;
   logic [instr_width_p-1:0] c1_instr_r, c2_instr_r;
   logic                     checkable, running, underflow, mismatch, hit;
   logic [2:0]               diff_code;
   logic [31:0]              match_cnt_r, fail_itag_r;
   logic [2:0]               fail_code_r;
   logic                     pass_r, fail_r;

   always_comb begin
      push_rec         = '0;
      push_rec.pc      = exp_pc_i;
      push_rec.instr   = exp_instr_i;
      push_rec.rd_w_v  = exp_rd_w_v_i;
      push_rec.rd_addr = exp_rd_addr_i;
      push_rec.rd_data = exp_rd_data_i;
      push_rec.last    = exp_last_i;
   end

   bsg_fifo_1r1w_small #(
      .width_p ($bits(bp_commit_trace_rec_s)),
      .els_p   (exp_fifo_els_p)
   ) exp_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (fifo_push),
      .ready_o   (fifo_ready),
      .data_i    (push_rec),
      .v_o       (fifo_v),
      .data_o    (head_rec),
      .yumi_i    (fifo_yumi)
   );

   // Two-stage commit delay so the compare stage lines up with the writeback ports.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         c1_v_r     <= 1'b0;
         c1_pc_r    <= '0;
         c1_instr_r <= '0;
         c2_v_r     <= 1'b0;
         c2_pc_r    <= '0;
         c2_instr_r <= '0;
      end else begin
         c1_v_r     <= commit_v_i;
         c1_pc_r    <= commit_pc_i;
         c1_instr_r <= commit_instr_i;
         c2_v_r     <= c1_v_r;
         c2_pc_r    <= c1_pc_r;
         c2_instr_r <= c1_instr_r;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= e_check_idle;
      else            state_r <= state_n;
   end

   always_comb begin
      state_n = state_r;
      case (state_r)
         e_check_idle: if (en_i) state_n = e_check_run;
         e_check_run: begin
            if (underflow || mismatch)     state_n = e_check_fail;
            else if (hit && head_rec.last) state_n = e_check_pass;
         end
         default: state_n = state_r;
      endcase
   end

   always_comb begin
      running     = (state_r == e_check_run);
      checkable   = c2_v_r && (c2_pc_r != '0);
      fifo_yumi   = running && checkable && fifo_v;
      underflow   = running && checkable && !fifo_v;
      diff_code   = bp_compare_rec(head_rec, c2_pc_r, c2_instr_r, rd_w_v_i, rd_addr_i, rd_data_i);
      hit         = fifo_yumi && (diff_code == 3'b000);
      mismatch    = fifo_yumi && (diff_code != 3'b000);
      exp_ready_o = fifo_ready && ((state_r == e_check_idle) || running);
      fifo_push   = exp_v_i && exp_ready_o;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         match_cnt_r <= '0;
         fail_itag_r <= '0;
         fail_code_r <= '0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
      end else begin
         pass_r <= (state_n == e_check_pass);
         fail_r <= (state_n == e_check_fail);
         if (hit && (match_cnt_r != '1))
            match_cnt_r <= match_cnt_r + 1'b1;
         if (underflow) begin
            fail_code_r <= 3'b111;
            fail_itag_r <= match_cnt_r;
         end else if (mismatch) begin
            fail_code_r <= diff_code;
            fail_itag_r <= match_cnt_r;
         end
      end
   end

   assign state_o     = state_r;
   assign match_cnt_o = match_cnt_r;
   assign fail_itag_o = fail_itag_r;
   assign fail_code_o = fail_code_r;
   assign pass_o      = pass_r;
   assign fail_o      = fail_r;

endmodule

// File: tb/tb_bp_commit_trace_checker.sv
// Directed bench for bp_commit_trace_checker: pass trace, instr/rd mismatches,
// zero-PC filtering, underflow, full-FIFO occupancy and async reset.
module tb_bp_commit_trace_checker;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        en_i;
   logic        exp_v_i;
   logic        exp_ready_o;
   logic [38:0] exp_pc_i;
   logic [31:0] exp_instr_i;
   logic        exp_rd_w_v_i;
   logic [4:0]  exp_rd_addr_i;
   logic [63:0] exp_rd_data_i;
   logic        exp_last_i;
   logic        commit_v_i;
   logic [38:0] commit_pc_i;
   logic [31:0] commit_instr_i;
   logic        rd_w_v_i;
   logic [4:0]  rd_addr_i;
   logic [63:0] rd_data_i;
   logic [1:0]  state_o;
   logic [31:0] match_cnt_o;
   logic [31:0] fail_itag_o;
   logic [2:0]  fail_code_o;
   logic        pass_o;
   logic        fail_o;

   int checks   = 0;
   int failures = 0;

   // Scoreboard: PCs of records loaded into the DUT, consumed by matching commits.
   logic [38:0] exp_q[$];

   bp_commit_trace_checker dut (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .en_i           (en_i),
      .exp_v_i        (exp_v_i),
      .exp_ready_o    (exp_ready_o),
      .exp_pc_i       (exp_pc_i),
      .exp_instr_i    (exp_instr_i),
      .exp_rd_w_v_i   (exp_rd_w_v_i),
      .exp_rd_addr_i  (exp_rd_addr_i),
      .exp_rd_data_i  (exp_rd_data_i),
      .exp_last_i     (exp_last_i),
      .commit_v_i     (commit_v_i),
      .commit_pc_i    (commit_pc_i),
      .commit_instr_i (commit_instr_i),
      .rd_w_v_i       (rd_w_v_i),
      .rd_addr_i      (rd_addr_i),
      .rd_data_i      (rd_data_i),
      .state_o        (state_o),
      .match_cnt_o    (match_cnt_o),
      .fail_itag_o    (fail_itag_o),
      .fail_code_o    (fail_code_o),
      .pass_o         (pass_o),
      .fail_o         (fail_o)
   );

   // Clock and watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic clear_inputs();
      en_i = 0; exp_v_i = 0; exp_pc_i = '0; exp_instr_i = '0; exp_rd_w_v_i = 0;
      exp_rd_addr_i = '0; exp_rd_data_i = '0; exp_last_i = 0;
      commit_v_i = 0; commit_pc_i = '0; commit_instr_i = '0;
      rd_w_v_i = 0; rd_addr_i = '0; rd_data_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      exp_q.delete();
      reset_n_i = 0;
      repeat (2) @(negedge clk_i);
      reset_n_i = 1;
      @(negedge clk_i);
   endtask

   task automatic push_rec(input logic [38:0] pc, input logic [31:0] instr, input logic wv,
                           input logic [4:0] addr, input logic [63:0] data, input logic last);
      @(negedge clk_i);
      exp_v_i = 1; exp_pc_i = pc; exp_instr_i = instr; exp_rd_w_v_i = wv;
      exp_rd_addr_i = addr; exp_rd_data_i = data; exp_last_i = last;
      exp_q.push_back(pc);
      @(negedge clk_i);
      exp_v_i = 0;
   endtask

   task automatic pulse_en();
      @(negedge clk_i);
      en_i = 1;
      @(negedge clk_i);
      en_i = 0;
   endtask

   // Commit, then its writeback two cycles later; push_wb raises exp_v_i on the compare edge.
   task automatic do_commit(input logic [38:0] pc, input logic [31:0] instr, input logic wv,
                            input logic [4:0] addr, input logic [63:0] data, input logic push_wb);
      @(negedge clk_i);
      commit_v_i = 1; commit_pc_i = pc; commit_instr_i = instr;
      @(negedge clk_i);
      commit_v_i = 0; commit_pc_i = '0; commit_instr_i = '0;
      @(negedge clk_i);
      rd_w_v_i = wv; rd_addr_i = addr; rd_data_i = data;
      if (push_wb) exp_v_i = 1;
      @(negedge clk_i);
      rd_w_v_i = 0; rd_addr_i = '0; rd_data_i = '0; exp_v_i = 0;
   endtask

   initial begin
      clear_inputs();
      reset_n_i = 1;

      // Reset state
      do_reset();
      chk("rst_state", state_o, 0);
      chk("rst_match", match_cnt_o, 0);
      chk("rst_itag", fail_itag_o, 0);
      chk("rst_code", fail_code_o, 0);
      chk("rst_pass", pass_o, 0);
      chk("rst_fail", fail_o, 0);
      chk("rst_ready", exp_ready_o, 1);

      // Three-record passing trace, with an IDLE commit and a zero-PC commit ignored
      push_rec(39'h80000000, 32'h00000013, 0, 5'd0, 64'h0, 0);
      push_rec(39'h80000004, 32'h00100093, 1, 5'd1, 64'h1, 0);
      push_rec(39'h80000008, 32'h00200113, 1, 5'd2, 64'h2, 1);
      do_commit(39'h80000000, 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("idle_commit_state", state_o, 0);
      chk("idle_commit_match", match_cnt_o, 0);
      pulse_en();
      chk("en_state", state_o, 1);
      do_commit(exp_q.pop_front(), 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("pass_match1", match_cnt_o, 1);
      do_commit(39'h0, 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("zero_pc_match", match_cnt_o, 1);
      chk("zero_pc_state", state_o, 1);
      do_commit(exp_q.pop_front(), 32'h00100093, 1, 5'd1, 64'h1, 0);
      chk("pass_match2", match_cnt_o, 2);
      chk("pass_early", pass_o, 0);
      do_commit(exp_q.pop_front(), 32'h00200113, 1, 5'd2, 64'h2, 0);
      chk("pass_match3", match_cnt_o, 3);
      chk("pass_o", pass_o, 1);
      chk("pass_state", state_o, 2);
      chk("pass_ready", exp_ready_o, 0);
      chk("pass_fail_o", fail_o, 0);

      // Instruction mismatch on the second commit
      do_reset();
      push_rec(39'h80000000, 32'h00000013, 0, 5'd0, 64'h0, 0);
      push_rec(39'h80000004, 32'h00100093, 1, 5'd1, 64'h1, 0);
      pulse_en();
      do_commit(exp_q.pop_front(), 32'h00000013, 0, 5'd0, 64'h0, 0);
      do_commit(exp_q.pop_front(), 32'h00000013, 1, 5'd1, 64'h1, 0);
      chk("instr_fail_o", fail_o, 1);
      chk("instr_code", fail_code_o, 3'b010);
      chk("instr_itag", fail_itag_o, 1);
      chk("instr_state", state_o, 3);
      chk("instr_match", match_cnt_o, 1);
      do_commit(39'h80000008, 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("fail_terminal_match", match_cnt_o, 1);
      chk("fail_terminal_state", state_o, 3);

      // Writeback data mismatch
      do_reset();
      push_rec(39'h80000000, 32'h00300193, 1, 5'd3, 64'h6, 1);
      pulse_en();
      do_commit(exp_q.pop_front(), 32'h00300193, 1, 5'd3, 64'h5, 0);
      chk("rd_code", fail_code_o, 3'b100);
      chk("rd_fail_o", fail_o, 1);
      chk("rd_itag", fail_itag_o, 0);

      // Underflow: commit with nothing buffered
      do_reset();
      pulse_en();
      do_commit(39'h80000000, 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("uflow_code", fail_code_o, 3'b111);
      chk("uflow_fail_o", fail_o, 1);

      // Fill to capacity, then push+pop at full-1 holds occupancy
      do_reset();
      for (int i = 0; i < 8; i++)
         push_rec(39'h80000000 + 39'(4 * i), 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("full_ready", exp_ready_o, 0);
      pulse_en();
      do_commit(exp_q.pop_front(), 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("full_m1_ready", exp_ready_o, 1);
      chk("full_m1_match", match_cnt_o, 1);
      exp_pc_i = 39'h80000020; exp_instr_i = 32'h00000013; exp_rd_w_v_i = 0;
      exp_rd_addr_i = '0; exp_rd_data_i = '0; exp_last_i = 0;
      exp_q.push_back(39'h80000020);
      do_commit(exp_q.pop_front(), 32'h00000013, 0, 5'd0, 64'h0, 1);
      chk("pushpop_ready", exp_ready_o, 1);
      chk("pushpop_match", match_cnt_o, 2);
      push_rec(39'h80000024, 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("refill_ready", exp_ready_o, 0);
      do_commit(exp_q.pop_front(), 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("order_match", match_cnt_o, 3);
      chk("order_state", state_o, 1);

      // Asynchronous reset mid-CHECK with a commit in flight
      do_reset();
      push_rec(39'h80000000, 32'h00000013, 0, 5'd0, 64'h0, 0);
      push_rec(39'h80000004, 32'h00000013, 0, 5'd0, 64'h0, 0);
      pulse_en();
      do_commit(exp_q.pop_front(), 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("arst_pre_match", match_cnt_o, 1);
      @(negedge clk_i);
      commit_v_i = 1; commit_pc_i = 39'h80000004; commit_instr_i = 32'h00000013;
      @(posedge clk_i);
      #2;
      reset_n_i = 0;
      commit_v_i = 0; commit_pc_i = '0; commit_instr_i = '0;
      #1;
      chk("arst_state", state_o, 0);
      chk("arst_match", match_cnt_o, 0);
      chk("arst_pass", pass_o, 0);
      chk("arst_fail", fail_o, 0);
      chk("arst_code", fail_code_o, 0);
      chk("arst_itag", fail_itag_o, 0);
      exp_q.delete();
      @(negedge clk_i);
      reset_n_i = 1;
      pulse_en();
      repeat (4) @(negedge clk_i);
      chk("arst_inflight_state", state_o, 1);
      chk("arst_inflight_fail", fail_o, 0);
      do_commit(39'h80000004, 32'h00000013, 0, 5'd0, 64'h0, 0);
      chk("arst_fifo_empty_code", fail_code_o, 3'b111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
